// File: rtl/digit_stroke_sequencer_pkg.sv
// Shared types and the glyph table for the digit stroke sequencer.
package stroke_pkg;

  localparam int GRID_W     = 3;
  localparam int N_DIGITS   = 10;
  localparam int GLYPH_PTS  = 8;

  // One glyph-grid point: target position, pen state and end-of-glyph flag.
  typedef struct packed {
    logic [GRID_W-1:0] gx;
    logic [GRID_W-1:0] gy;
    logic              pen;
    logic              last;
  } point_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_HOME  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  function automatic point_t pt(input int x, input int y, input int pen, input int last);
    point_t p;
    p.gx   = GRID_W'(x);
    p.gy   = GRID_W'(y);
    p.pen  = (pen != 0);
    p.last = (last != 0);
    return p;
  endfunction

  // Glyph strokes on a 4x5 grid (x 0..3, y 0..4). Unused slots and
  // unknown digits read as a pen-up terminator so the walk always ends.
  function automatic point_t glyph_point(input int unsigned d, input int unsigned i);
    point_t p;
    p = pt(0, 0, 0, 1);
    case (d)
      0: case (i)
           0: p = pt(0,0,0,0); 1: p = pt(3,0,1,0); 2: p = pt(3,4,1,0);
           3: p = pt(0,4,1,0); 4: p = pt(0,0,1,1); default: ;
         endcase
      1: case (i)
           0: p = pt(2,0,0,0); 1: p = pt(2,4,1,1); default: ;
         endcase
      2: case (i)
           0: p = pt(0,0,0,0); 1: p = pt(3,0,1,0); 2: p = pt(3,2,1,0);
           3: p = pt(0,2,1,0); 4: p = pt(0,4,1,0); 5: p = pt(3,4,1,1); default: ;
         endcase
      3: case (i)
           0: p = pt(0,0,0,0); 1: p = pt(3,0,1,0); 2: p = pt(3,4,1,0);
           3: p = pt(0,4,1,0); 4: p = pt(0,2,0,0); 5: p = pt(3,2,1,1); default: ;
         endcase
      4: case (i)
           0: p = pt(0,0,0,0); 1: p = pt(0,2,1,0); 2: p = pt(3,2,1,0);
           3: p = pt(3,0,0,0); 4: p = pt(3,4,1,1); default: ;
         endcase
      5: case (i)
           0: p = pt(3,0,0,0); 1: p = pt(0,0,1,0); 2: p = pt(0,2,1,0);
           3: p = pt(3,2,1,0); 4: p = pt(3,4,1,0); 5: p = pt(0,4,1,1); default: ;
         endcase
      6: case (i)
           0: p = pt(3,0,0,0); 1: p = pt(0,0,1,0); 2: p = pt(0,4,1,0);
           3: p = pt(3,4,1,0); 4: p = pt(3,2,1,0); 5: p = pt(0,2,1,1); default: ;
         endcase
      7: case (i)
           0: p = pt(0,0,0,0); 1: p = pt(3,0,1,0); 2: p = pt(1,4,1,1); default: ;
         endcase
      8: case (i)
           0: p = pt(0,0,0,0); 1: p = pt(3,0,1,0); 2: p = pt(3,4,1,0); 3: p = pt(0,4,1,0);
           4: p = pt(0,0,1,0); 5: p = pt(0,2,0,0); 6: p = pt(3,2,1,1); default: ;
         endcase
      9: case (i)
           0: p = pt(3,2,0,0); 1: p = pt(0,2,1,0); 2: p = pt(0,0,1,0);
           3: p = pt(3,0,1,0); 4: p = pt(3,4,1,1); default: ;
         endcase
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/digit_stroke_sequencer_if.sv
// Stroke channel from the sequencer to the motion controller.
// Handshake: a stroke transfers on a clk edge where stroke_valid and
// stroke_ready are both high; while valid is high and ready is low every
// stroke field holds steady, and valid never drops without a transfer.
interface digit_stroke_sequencer_if #(parameter int COORD_W = 8);
  logic               stroke_valid;
  logic               stroke_ready;
  logic [COORD_W-1:0] start_x;
  logic [COORD_W-1:0] start_y;
  logic [COORD_W-1:0] end_x;
  logic [COORD_W-1:0] end_y;
  logic               pen_down;

  modport master (output stroke_valid, start_x, start_y, end_x, end_y, pen_down,
                  input  stroke_ready);
  modport slave  (input  stroke_valid, start_x, start_y, end_x, end_y, pen_down,
                  output stroke_ready);
endinterface

// File: rtl/digit_point_rom.sv
// Combinational glyph lookup: (digit, point index) -> grid point.
module digit_point_rom
  import stroke_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic [3:0]       digit,
  input  logic [IDX_W-1:0] idx,
  output point_t           pt_o
);

  // Table read; out-of-range digits fall through to the terminator entry.
  always_comb begin
    pt_o = glyph_point(32'(digit), 32'(idx));
  end

endmodule

// File: rtl/digit_stroke_sequencer.sv
// Walks one digit's glyph table, scaling and offsetting each point, and
// emits strokes over a valid/ready channel, finishing with a pen-up home move.
module digit_stroke_sequencer
  import stroke_pkg::*;
#(
  parameter int COORD_W     = 8,
  parameter int MAX_PTS     = 8,
  parameter int SCALE_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         digit,
  input  logic [COORD_W-1:0] org_x,
  input  logic [COORD_W-1:0] org_y,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err,
  output state_t             state_o,
  digit_stroke_sequencer_if.master stroke
);

  localparam int IDX_W = $clog2(MAX_PTS);

  state_t             state_q, state_d;
  logic [3:0]         digit_q, digit_d;
  logic [COORD_W-1:0] org_x_q, org_x_d, org_y_q, org_y_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [COORD_W-1:0] end_x_q, end_x_d, end_y_q, end_y_d;
  logic               pen_q, pen_d, last_q, last_d;
  logic               abort_pend_q, abort_pend_d;
  logic               err_q, err_d;
  logic               valid_w, xfer_w;
  point_t             rom_pt;

  // Grid-to-plotter mapping with one guard bit so overflow clamps to full scale.
  function automatic logic [COORD_W-1:0] scale_sat(input logic [COORD_W-1:0] org,
                                                   input logic [GRID_W-1:0] g);
    logic [COORD_W:0] sum;
    sum = {1'b0, org} + ((COORD_W+1)'(g) << SCALE_SHIFT);
    return sum[COORD_W] ? '1 : sum[COORD_W-1:0];
  endfunction

  digit_point_rom #(.IDX_W(IDX_W)) u_rom (
    .digit (digit_q),
    .idx   (idx_q),
    .pt_o  (rom_pt)
  );

  assign valid_w = (state_q == S_ISSUE) || (state_q == S_HOME);
  assign xfer_w  = valid_w && stroke.stroke_ready;

  // Next-state and datapath updates for the stroke walk.
  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    org_x_d      = org_x_q;
    org_y_d      = org_y_q;
    idx_d        = idx_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    end_x_d      = end_x_q;
    end_y_d      = end_y_q;
    pen_d        = pen_q;
    last_d       = last_q;
    abort_pend_d = abort_pend_q | ((state_q != S_IDLE) & abort);
    err_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (digit <= 4'(N_DIGITS - 1)) begin
            digit_d = digit;
            org_x_d = org_x;
            org_y_d = org_y;
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        end_x_d = scale_sat(org_x_q, rom_pt.gx);
        end_y_d = scale_sat(org_y_q, rom_pt.gy);
        pen_d   = rom_pt.pen;
        last_d  = rom_pt.last;
        state_d = (abort || abort_pend_q) ? S_HOME : S_ISSUE;
      end
      S_ISSUE: begin
        if (xfer_w) begin
          cur_x_d = end_x_q;
          cur_y_d = end_y_q;
          if (last_q || abort_pend_q || abort) begin
            state_d = S_HOME;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_HOME: begin
        if (xfer_w) begin
          cur_x_d = '0;
          cur_y_d = '0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        abort_pend_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      digit_q      <= '0;
      org_x_q      <= '0;
      org_y_q      <= '0;
      idx_q        <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      end_x_q      <= '0;
      end_y_q      <= '0;
      pen_q        <= 1'b0;
      last_q       <= 1'b0;
      abort_pend_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      org_x_q      <= org_x_d;
      org_y_q      <= org_y_d;
      idx_q        <= idx_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      end_x_q      <= end_x_d;
      end_y_q      <= end_y_d;
      pen_q        <= pen_d;
      last_q       <= last_d;
      abort_pend_q <= abort_pend_d;
      err_q        <= err_d;
    end
  end

  // Stroke fields come straight from registers, so they hold while stalled.
  always_comb begin
    stroke.stroke_valid = valid_w;
    stroke.start_x      = valid_w ? cur_x_q : '0;
    stroke.start_y      = valid_w ? cur_y_q : '0;
    stroke.end_x        = (state_q == S_ISSUE) ? end_x_q : '0;
    stroke.end_y        = (state_q == S_ISSUE) ? end_y_q : '0;
    stroke.pen_down     = (state_q == S_ISSUE) && pen_q;
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_FIN);
  assign err     = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_digit_stroke_sequencer.sv
// Directed bench for digit_stroke_sequencer.
module tb_digit_stroke_sequencer;
  import stroke_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] digit;
  logic [7:0] org_x;
  logic [7:0] org_y;
  logic       busy;
  logic       done;
  logic       err;
  state_t     state_o;
  int         n_cmp;
  int         n_mis;

  digit_stroke_sequencer_if #(.COORD_W(8)) sif ();

  digit_stroke_sequencer #(.COORD_W(8), .MAX_PTS(8), .SCALE_SHIFT(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .digit   (digit),
    .org_x   (org_x),
    .org_y   (org_y),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .state_o (state_o),
    .stroke  (sif)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".valid"}, 32'(sif.stroke_valid), 0);
    chk({tag, ".busy"},  32'(busy), 0);
    chk({tag, ".done"},  32'(done), 0);
    chk({tag, ".err"},   32'(err), 0);
    chk({tag, ".sx"},    32'(sif.start_x), 0);
    chk({tag, ".sy"},    32'(sif.start_y), 0);
    chk({tag, ".ex"},    32'(sif.end_x), 0);
    chk({tag, ".ey"},    32'(sif.end_y), 0);
    chk({tag, ".pen"},   32'(sif.pen_down), 0);
    chk({tag, ".state"}, 32'(state_o), 32'(S_IDLE));
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (sif.stroke_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, ".valid"}, 32'(sif.stroke_valid), 1);
  endtask

  task automatic check_fields(input string tag, input int sx, input int sy,
                              input int ex, input int ey, input int pd);
    chk({tag, ".sx"},  32'(sif.start_x), sx);
    chk({tag, ".sy"},  32'(sif.start_y), sy);
    chk({tag, ".ex"},  32'(sif.end_x), ex);
    chk({tag, ".ey"},  32'(sif.end_y), ey);
    chk({tag, ".pen"}, 32'(sif.pen_down), pd);
  endtask

  // Wait for a stroke, check it, then let one edge pass (transfers if ready=1).
  task automatic stroke(input string tag, input int sx, input int sy,
                        input int ex, input int ey, input int pd);
    wait_valid(tag);
    check_fields(tag, sx, sy, ex, ey, pd);
    step();
  endtask

  task automatic launch(input logic [3:0] d, input int ox, input int oy);
    start = 1'b1;
    digit = d;
    org_x = 8'(ox);
    org_y = 8'(oy);
    step();
    start = 1'b0;
  endtask

  task automatic finish_draw(input string tag);
    chk({tag, ".done"}, 32'(done), 1);
    step();
    chk({tag, ".done_off"}, 32'(done), 0);
    chk({tag, ".busy_off"}, 32'(busy), 0);
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    digit = '0;
    org_x = '0;
    org_y = '0;
    sif.stroke_ready = 1'b1;
    repeat (3) step();
    check_idle("reset");
    rst_n = 1'b1;
    step();

    // Digit 1 at (10,20), controller always ready.
    launch(4'd1, 10, 20);
    chk("t1.busy", 32'(busy), 1);
    chk("t1.lat1", 32'(sif.stroke_valid), 0);
    step();
    chk("t1.lat2", 32'(sif.stroke_valid), 1);
    stroke("t1.s1", 0, 0, 42, 20, 0);
    stroke("t1.s2", 42, 20, 42, 84, 1);
    stroke("t1.home", 42, 84, 0, 0, 0);
    finish_draw("t1");

    // Same draw with the second stroke stalled for 5 cycles.
    launch(4'd1, 10, 20);
    stroke("t2.s1", 0, 0, 42, 20, 0);
    sif.stroke_ready = 1'b0;
    wait_valid("t2.s2");
    for (int k = 0; k < 5; k++) begin
      chk("t2.stall_valid", 32'(sif.stroke_valid), 1);
      check_fields("t2.stall", 42, 20, 42, 84, 1);
      step();
    end
    sif.stroke_ready = 1'b1;
    step();
    chk("t2.after_state", 32'(state_o), 32'(S_HOME));
    stroke("t2.home", 42, 84, 0, 0, 0);
    finish_draw("t2");

    // Saturating X.
    launch(4'd1, 250, 0);
    stroke("t3.s1", 0, 0, 255, 0, 0);
    stroke("t3.s2", 255, 0, 255, 64, 1);
    stroke("t3.home", 255, 64, 0, 0, 0);
    finish_draw("t3");

    // Illegal digit.
    launch(4'd12, 5, 5);
    chk("t4.err", 32'(err), 1);
    chk("t4.busy", 32'(busy), 0);
    chk("t4.valid", 32'(sif.stroke_valid), 0);
    step();
    chk("t4.err_off", 32'(err), 0);
    chk("t4.valid2", 32'(sif.stroke_valid), 0);
    chk("t4.state", 32'(state_o), 32'(S_IDLE));

    // Digit 7, abort while stroke 2 is stalled; stray start while busy.
    launch(4'd7, 0, 0);
    stroke("t5.s1", 0, 0, 0, 0, 0);
    sif.stroke_ready = 1'b0;
    wait_valid("t5.s2");
    check_fields("t5.s2", 0, 0, 48, 0, 1);
    abort = 1'b1;
    start = 1'b1;
    digit = 4'd12;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("t5.no_err", 32'(err), 0);
    chk("t5.hold_valid", 32'(sif.stroke_valid), 1);
    check_fields("t5.hold", 0, 0, 48, 0, 1);
    step();
    chk("t5.hold_valid2", 32'(sif.stroke_valid), 1);
    sif.stroke_ready = 1'b1;
    step();
    chk("t5.home_state", 32'(state_o), 32'(S_HOME));
    stroke("t5.home", 48, 0, 0, 0, 0);
    finish_draw("t5");

    // Reset in the middle of a stalled stroke, then a clean redraw.
    launch(4'd1, 10, 20);
    stroke("t6.s1", 0, 0, 42, 20, 0);
    sif.stroke_ready = 1'b0;
    wait_valid("t6.s2");
    chk("t6.mid_state", 32'(state_o), 32'(S_ISSUE));
    rst_n = 1'b0;
    step();
    check_idle("t6.rst");
    rst_n = 1'b1;
    sif.stroke_ready = 1'b1;
    step();
    launch(4'd1, 10, 20);
    stroke("t6.r1", 0, 0, 42, 20, 0);
    stroke("t6.r2", 42, 20, 42, 84, 1);
    stroke("t6.home", 42, 84, 0, 0, 0);
    finish_draw("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
